// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice.
// Holds the command encodings, the FSM state encoding and the default
// addresses of the memory-mapped I/O registers.
package mem_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RD       = 2'b01,
    DONE     = 2'b10,
    WAIT_CLR = 2'b11
  } state_e;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

endpackage

// File: rtl/mem_ram.sv
// Single-port RAM: WORDS x DW, synchronous write, registered synchronous read.
// Contents and the read register are not reset.
// Ports:
//   clk   - clock
//   we    - write enable (writes wdata to addr on the rising edge)
//   re    - read enable (loads rdata from addr on the rising edge)
//   addr  - word address
//   wdata - write data
//   rdata - registered read data
module mem_ram #(
  parameter int WORDS = 256,
  parameter int DW    = 16,
  parameter int RA    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [RA-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves CPU read/write commands from a RAM or from
// memory-mapped I/O (switch input, LED register) and signals completion
// with a one-cycle mem_done pulse. The requester holds the command until
// done; the responder then waits for the command to drop before the next.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   mem_cmd     - 00 none, 01 read, 10 write, 11 reserved (as none)
//   mem_addr    - access address
//   write_data  - write data
//   SW          - raw board switches (asynchronous)
//   read_data   - read result, valid while mem_done is high
//   mem_done    - one-cycle completion pulse
//   bad_addr    - with mem_done, the address decoded to nothing
//   LEDR        - LED register
module mem_responder
  import mem_pkg::*;
#(
  parameter int          AW        = 9,
  parameter int          DW        = 16,
  parameter int          RAM_WORDS = 256,
  parameter logic [AW-1:0] LED_ADDR = AW'(LED_ADDR_DEF),
  parameter logic [AW-1:0] SW_ADDR  = AW'(SW_ADDR_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mem_cmd,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] write_data,
  input  logic [7:0]    SW,
  output logic [DW-1:0] read_data,
  output logic          mem_done,
  output logic          bad_addr,
  output logic [7:0]    LEDR
);

  localparam int RA = $clog2(RAM_WORDS);

  state_e        state, nxt;
  logic [AW-1:0] addr_q;
  logic [7:0]    sw_meta, sw_sync;
  logic [DW-1:0] ram_q;

  logic is_rd, is_wr, is_none;
  assign is_rd   = (mem_cmd == MREAD);
  assign is_wr   = (mem_cmd == MWRITE);
  assign is_none = !is_rd && !is_wr;

  logic acc_rd, acc_wr;
  assign acc_rd = (state == IDLE) && is_rd;
  assign acc_wr = (state == IDLE) && is_wr;

  // Switch synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  // RAM is addressed straight from the bus on the accepting edge, so the
  // read data is ready one edge later in RD. The write is gated by reset
  // because the array itself has no reset path.
  logic ram_we, wr_in_ram;
  assign wr_in_ram = (mem_addr < AW'(RAM_WORDS));
  assign ram_we    = acc_wr && wr_in_ram && !reset;

  mem_ram #(.WORDS(RAM_WORDS), .DW(DW), .RA(RA)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (acc_rd),
    .addr  (mem_addr[RA-1:0]),
    .wdata (write_data),
    .rdata (ram_q)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (is_rd) nxt = RD;
                else if (is_wr) nxt = DONE;
      RD:       nxt = DONE;
      DONE:     nxt = (mem_cmd == MNONE) ? IDLE : WAIT_CLR;
      WAIT_CLR: if (is_none) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Output decode: read value and bad-address flags for the pending access
  logic [DW-1:0] rd_val;
  logic          rd_bad, wr_bad;
  always_comb begin
    rd_val = '0;
    rd_bad = 1'b0;
    if (addr_q < AW'(RAM_WORDS)) rd_val = ram_q;
    else if (addr_q == SW_ADDR)  rd_val = DW'(sw_sync);
    else if (addr_q == LED_ADDR) rd_val = DW'(LEDR);
    else                         rd_bad = 1'b1;
    wr_bad = !wr_in_ram && (mem_addr != LED_ADDR);
  end

  // Registered outputs and I/O registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
      mem_done  <= 1'b0;
      bad_addr  <= 1'b0;
      LEDR      <= '0;
      addr_q    <= '0;
    end else begin
      // DONE is only entered from IDLE (write) or RD, so this is one cycle
      mem_done <= (nxt == DONE);
      bad_addr <= 1'b0;
      if (acc_rd) addr_q <= mem_addr;
      if (acc_wr) begin
        bad_addr <= wr_bad;
        if (mem_addr == LED_ADDR) LEDR <= write_data[7:0];
      end
      if (state == RD) begin
        read_data <= rd_val;
        bad_addr  <= rd_bad;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM and I/O read/write, latencies,
// bad-address decode, switch synchroniser delay, held-command single
// completion, and reset in mid-transaction.
module tb_mem_responder;
  import mem_pkg::*;

  logic        clk = 0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  SW;
  logic [15:0] read_data;
  logic        mem_done;
  logic        bad_addr;
  logic [7:0]  LEDR;

  int n_chk = 0;
  int n_pass = 0;

  mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .SW         (SW),
    .read_data  (read_data),
    .mem_done   (mem_done),
    .bad_addr   (bad_addr),
    .LEDR       (LEDR)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got %h exp %h", tag, got, exp);
    else n_pass++;
  endtask

  // Drive a command (and switches) at a falling edge, wait for mem_done,
  // capture results, drop the command and confirm the pulse lasted one cycle.
  task automatic xact(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                      input logic [7:0] sw_v, output int lat, output logic [15:0] rd,
                      output logic bad);
    @(negedge clk);
    mem_cmd = c; mem_addr = a; write_data = d; SW = sw_v;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_done && lat < 20);
    if (!mem_done) lat = -1;
    rd  = read_data;
    bad = bad_addr;
    @(negedge clk);
    mem_cmd = MNONE;
    @(posedge clk); #1;
    chk("done_one_cycle", mem_done, 0);
  endtask

  int          lat, pulses;
  logic [15:0] rd;
  logic        bad;

  initial begin
    reset = 1; mem_cmd = MNONE; mem_addr = '0; write_data = '0; SW = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", mem_done, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_bad", bad_addr, 0);
    chk("rst_ledr", LEDR, 0);
    @(negedge clk); reset = 0;

    // RAM write then read back
    xact(MWRITE, 9'h005, 16'hBEEF, 8'h00, lat, rd, bad);
    chk("wr5_lat", lat, 1);
    chk("wr5_bad", bad, 0);
    xact(MREAD, 9'h005, 16'h0000, 8'h00, lat, rd, bad);
    chk("rd5_lat", lat, 2);
    chk("rd5_data", rd, 16'hBEEF);
    chk("rd5_bad", bad, 0);

    // LED register
    xact(MWRITE, 9'h100, 16'h12A5, 8'h00, lat, rd, bad);
    chk("wrled_lat", lat, 1);
    chk("wrled_ledr", LEDR, 8'hA5);
    xact(MREAD, 9'h100, 16'h0000, 8'h00, lat, rd, bad);
    chk("rdled_data", rd, 16'h00A5);
    chk("rdled_bad", bad, 0);

    // Switches through the synchroniser
    @(negedge clk); SW = 8'h3C;
    repeat (3) @(posedge clk);
    xact(MREAD, 9'h140, 16'h0000, 8'h3C, lat, rd, bad);
    chk("rdsw_data", rd, 16'h003C);
    // switch change lands together with the command: old value is returned
    xact(MREAD, 9'h140, 16'h0000, 8'hFF, lat, rd, bad);
    chk("rdsw_old", rd, 16'h003C);
    xact(MREAD, 9'h140, 16'h0000, 8'hFF, lat, rd, bad);
    chk("rdsw_new", rd, 16'h00FF);

    // Unmapped addresses
    xact(MREAD, 9'h1FF, 16'h0000, 8'hFF, lat, rd, bad);
    chk("rdbad_lat", lat, 2);
    chk("rdbad_data", rd, 16'h0000);
    chk("rdbad_bad", bad, 1);
    xact(MWRITE, 9'h080, 16'h1234, 8'hFF, lat, rd, bad);
    xact(MWRITE, 9'h180, 16'hFFFF, 8'hFF, lat, rd, bad);
    chk("wrbad_lat", lat, 1);
    chk("wrbad_bad", bad, 1);
    chk("wrbad_ledr", LEDR, 8'hA5);
    xact(MWRITE, 9'h140, 16'hFFFF, 8'hFF, lat, rd, bad);
    chk("wrsw_bad", bad, 1);
    xact(MREAD, 9'h080, 16'h0000, 8'hFF, lat, rd, bad);
    chk("rd80_data", rd, 16'h1234);
    chk("rd80_bad", bad, 0);

    // Reserved command never completes
    @(negedge clk); mem_cmd = 2'b11; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (mem_done) pulses++;
    end
    chk("reserved_nodone", pulses, 0);
    @(negedge clk); mem_cmd = MNONE;

    // Held command: one completion; address change after accept ignored
    @(negedge clk); mem_cmd = MREAD; mem_addr = 9'h005; pulses = 0; rd = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) mem_addr = 9'h140;
      if (mem_done) begin pulses++; rd = read_data; end
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_data", rd, 16'hBEEF);
    @(negedge clk); mem_cmd = MNONE;
    @(posedge clk);
    xact(MREAD, 9'h005, 16'h0000, 8'hFF, lat, rd, bad);
    chk("reissue_lat", lat, 2);

    // Reset while in RD
    @(negedge clk); mem_cmd = MREAD; mem_addr = 9'h005; pulses = 0;
    @(posedge clk); #1;
    reset = 1; mem_cmd = MNONE;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_done) pulses++;
    end
    chk("rst_ledr_clr", LEDR, 0);
    @(negedge clk); reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_done) pulses++;
    end
    chk("rst_nodone", pulses, 0);
    xact(MREAD, 9'h005, 16'h0000, 8'hFF, lat, rd, bad);
    chk("postrst_lat", lat, 2);
    chk("postrst_data", rd, 16'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
